// File: rtl/vga_pattern_checker_pkg.sv
// Shared lane geometry, FSM state type and run-counter width for the VGA pattern checker.
package vga_chk_pkg;

    localparam int NUM_LANES = 8;
    localparam int RUN_W     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic int lane_lsb(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            2:       return 4;
            3:       return 6;
            4:       return 10;
            5:       return 14;
            6:       return 18;
            default: return 22;
        endcase
    endfunction

    // Lanes 3..7 carry a 4-bit field whose upper two bits must be zero.
    function automatic int lane_width(input int k);
        return (k < 3) ? 2 : 4;
    endfunction

endpackage

// File: rtl/vga_pattern_checker_if.sv
// Pattern bus into the checker plus its status/count outputs; master = pattern source/debug side.
interface vga_pattern_checker_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             clr_cnt;
    logic [47:0]      pat_in;
    logic             locked;
    logic             err_pulse;
    logic [7:0]       err_lane;
    logic [7:0]       err_lane_sticky;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    modport master (
        output en, clr_cnt, pat_in,
        input  locked, err_pulse, err_lane, err_lane_sticky, err_count, word_count
    );

    modport slave (
        input  en, clr_cnt, pat_in,
        output locked, err_pulse, err_lane, err_lane_sticky, err_count, word_count
    );
endinterface

// File: rtl/vga_pattern_checker_lane_cmp.sv
// One lane compare: low 2 bits vs expected value, plus zero check on the upper bits of wide lanes.
// Latency: combinational. Backpressure: none.
// Used once per lane by vga_pattern_checker.
module vga_chk_lane_cmp (
    input  logic [3:0] i_field,
    input  logic [1:0] i_exp,
    input  logic       i_is_wide,
    output logic       o_err
);
    assign o_err = (i_field[1:0] != i_exp) | (i_is_wide & (|i_field[3:2]));
endmodule

// File: rtl/vga_pattern_checker.sv
// Checks the staggered-counter VGA bring-up pattern: per-lane errors, lock FSM, saturating counts.
// Latency: all outputs registered, 1 cycle after the sampled word. Backpressure: none; en=0 pauses and invalidates history.
// Optional VGA_CHK_STICKY_EN adds an OR-accumulated per-lane error mask on err_lane_sticky.
module vga_pattern_checker
    import vga_chk_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int LOCK_CNT    = 4,
    parameter int LOSS_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_pattern_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RUN_W-1:0]   r_clean_run;
    logic [RUN_W-1:0]   r_bad_run;
    logic [RUN_W-1:0]   w_clean_nxt;
    logic [RUN_W-1:0]   w_bad_nxt;
    logic [RUN_W-1:0]   w_clean_inc;
    logic [RUN_W-1:0]   w_bad_inc;

    logic [1:0]         r_hist [NUM_LANES-1];
    logic               r_hist_vld;
    logic [1:0]         w_lane_val [NUM_LANES];
    logic [NUM_LANES-1:0] w_err_lane;
    logic               w_check;
    logic               w_err;

    logic               r_err_pulse;
    logic [7:0]         r_err_lane;
    logic [CNT_W-1:0]   r_err_count;
    logic [CNT_W-1:0]   r_word_count;
    logic               w_unused_bits;

    assign w_unused_bits = ^bus.pat_in[47:26];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam int LSB = lane_lsb(k);
        localparam bit WIDE = (lane_width(k) == 4);
        logic [3:0] w_field;
        logic [1:0] w_exp;

        if (WIDE) begin : g_wide
            assign w_field = bus.pat_in[LSB +: 4];
        end else begin : g_narrow
            assign w_field = {2'b00, bus.pat_in[LSB +: 2]};
        end

        if (k == 0) begin : g_inc
            assign w_exp = r_hist[0] + 2'd1;
        end else begin : g_shift
            assign w_exp = r_hist[k-1];
        end

        assign w_lane_val[k] = w_field[1:0];

        vga_chk_lane_cmp u_cmp (
            .i_field   (w_field),
            .i_exp     (w_exp),
            .i_is_wide (WIDE),
            .o_err     (w_err_lane[k])
        );
    end

    assign w_check     = bus.en & r_hist_vld;
    assign w_err       = |w_err_lane;
    assign w_clean_inc = r_clean_run + 1'b1;
    assign w_bad_inc   = r_bad_run + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_clean_nxt = r_clean_run;
        w_bad_nxt   = r_bad_run;
        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_state_nxt = ACQUIRE;
                    w_clean_nxt = '0;
                    w_bad_nxt   = '0;
                end
            end
            ACQUIRE: begin
                if (w_check) begin
                    if (w_err) begin
                        w_clean_nxt = '0;
                    end else if (w_clean_inc == RUN_W'(LOCK_CNT)) begin
                        w_state_nxt = LOCKED;
                        w_clean_nxt = '0;
                        w_bad_nxt   = '0;
                    end else begin
                        w_clean_nxt = w_clean_inc;
                    end
                end
            end
            LOCKED: begin
                if (w_check) begin
                    if (!w_err) begin
                        w_bad_nxt = '0;
                    end else if (w_bad_inc == RUN_W'(LOSS_THRESH)) begin
                        w_state_nxt = ACQUIRE;
                        w_clean_nxt = '0;
                        w_bad_nxt   = '0;
                    end else begin
                        w_bad_nxt = w_bad_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_clean_nxt = '0;
                w_bad_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_clean_run <= '0;
            r_bad_run   <= '0;
            r_hist_vld  <= 1'b0;
            for (int k = 0; k < NUM_LANES - 1; k++) r_hist[k] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clean_run <= w_clean_nxt;
            r_bad_run   <= w_bad_nxt;
            r_hist_vld  <= bus.en;
            if (bus.en) begin
                for (int k = 0; k < NUM_LANES - 1; k++) r_hist[k] <= w_lane_val[k];
            end
        end
    end

    // A clear coinciding with a checked word restarts the counts from that word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_pulse  <= 1'b0;
            r_err_lane   <= '0;
            r_err_count  <= '0;
            r_word_count <= '0;
        end else begin
            r_err_pulse <= w_check & w_err;
            if (w_check) r_err_lane <= w_err_lane;
            if (bus.clr_cnt) begin
                r_word_count <= w_check ? CNT_W'(1) : '0;
                r_err_count  <= (w_check & w_err) ? CNT_W'(1) : '0;
            end else if (w_check) begin
                if (r_word_count != CNT_MAX) r_word_count <= r_word_count + 1'b1;
                if (w_err && r_err_count != CNT_MAX) r_err_count <= r_err_count + 1'b1;
            end
        end
    end

`ifdef VGA_CHK_STICKY_EN
    logic [7:0] r_sticky;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (bus.clr_cnt) begin
            r_sticky <= w_check ? w_err_lane : '0;
        end else if (w_check) begin
            r_sticky <= r_sticky | w_err_lane;
        end
    end

    assign bus.err_lane_sticky = r_sticky;
`else
    assign bus.err_lane_sticky = 8'h00;
`endif

    assign bus.locked     = (r_state == LOCKED);
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_lane   = r_err_lane;
    assign bus.err_count  = r_err_count;
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_vga_pattern_checker.sv
// Directed bench for vga_pattern_checker: a 16-bit-counter and a 4-bit-counter instance share one stimulus stream.
module tb_vga_pattern_checker;

`ifdef VGA_CHK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr_cnt;
    logic [47:0] pat_in;
    int          gc;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    vga_pattern_checker_if #(.CNT_W(16)) if16 ();
    vga_pattern_checker_if #(.CNT_W(4))  if4 ();

    assign if16.en      = en;
    assign if16.clr_cnt = clr_cnt;
    assign if16.pat_in  = pat_in;
    assign if4.en       = en;
    assign if4.clr_cnt  = clr_cnt;
    assign if4.pat_in   = pat_in;

    vga_pattern_checker #(.CNT_W(16), .LOCK_CNT(4), .LOSS_THRESH(2)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    vga_pattern_checker #(.CNT_W(4), .LOCK_CNT(4), .LOSS_THRESH(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    // Staggered counter word: lane k carries (c - k) mod 4; ignored high bits get junk.
    function automatic logic [47:0] gen_word(input int c);
        logic [47:0] w;
        int lsb;
        w = '0;
        w[47:26] = 22'h2AAAAA;
        for (int k = 0; k < 8; k++) begin
            lsb = (k < 3) ? 2 * k : 6 + 4 * (k - 3);
            w[lsb +: 2] = 2'(c - k);
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [47:0] w);
        pat_in = w;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr_cnt = 1'b0; pat_in = '0;
        tick(); tick();
        total++; if (if16.locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", if16.locked); else passed++;
        total++; if (if16.err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %0b want 0", if16.err_pulse); else passed++;
        total++; if (if16.err_lane !== 8'h00) $display("FAIL reset_err_lane: got %0h want 00", if16.err_lane); else passed++;
        total++; if (if16.err_count !== 16'd0) $display("FAIL reset_err_count: got %0d want 0", if16.err_count); else passed++;
        total++; if (if16.word_count !== 16'd0) $display("FAIL reset_word_count: got %0d want 0", if16.word_count); else passed++;
        total++; if (if16.err_lane_sticky !== 8'h00) $display("FAIL reset_sticky: got %0h want 00", if16.err_lane_sticky); else passed++;
        total++; if (if4.word_count !== 4'd0) $display("FAIL reset_word_count4: got %0d want 0", if4.word_count); else passed++;
    endtask

    task automatic test_clean_lock();
        rst_n = 1'b1; en = 1'b1; gc = 0;
        for (int i = 0; i < 10; i++) begin
            send(gen_word(gc)); gc++;
            if (i == 3) begin
                total++; if (if16.locked !== 1'b0) $display("FAIL lock_early: got %0b want 0", if16.locked); else passed++;
            end
            if (i == 4) begin
                total++; if (if16.locked !== 1'b1) $display("FAIL lock_on_time: got %0b want 1", if16.locked); else passed++;
            end
        end
        total++; if (if16.word_count !== 16'd9) $display("FAIL clean_word_count: got %0d want 9", if16.word_count); else passed++;
        total++; if (if16.err_count !== 16'd0) $display("FAIL clean_err_count: got %0d want 0", if16.err_count); else passed++;
        total++; if (if16.err_lane !== 8'h00) $display("FAIL clean_err_lane: got %0h want 00", if16.err_lane); else passed++;
    endtask

    task automatic test_lane0_stuck();
        logic [47:0] w;
        send(gen_word(gc)); gc++;          // gc now 11, v_0 = 3 so stuck value 2 is wrong
        w = gen_word(gc); gc++;
        w[1:0] = 2'd2;
        send(w);
        total++; if (if16.err_lane !== 8'h01) $display("FAIL stuck_lane_1st: got %0h want 01", if16.err_lane); else passed++;
        total++; if (if16.locked !== 1'b1) $display("FAIL stuck_locked_1st: got %0b want 1", if16.locked); else passed++;
        // Next word: L0 expects stuck+1=3 (gets 0), L1 expects stuck 2 (gets 3).
        send(gen_word(gc)); gc++;
        total++; if (if16.err_lane !== 8'h03) $display("FAIL stuck_lane_2nd: got %0h want 03", if16.err_lane); else passed++;
        total++; if (if16.locked !== 1'b0) $display("FAIL stuck_loss: got %0b want 0", if16.locked); else passed++;
        total++; if (if16.err_count !== 16'd2) $display("FAIL stuck_err_count: got %0d want 2", if16.err_count); else passed++;
        for (int i = 0; i < 4; i++) begin
            send(gen_word(gc)); gc++;
            if (i == 0) begin
                total++; if (if16.err_lane !== 8'h00) $display("FAIL stuck_recover_lane: got %0h want 00", if16.err_lane); else passed++;
            end
            if (i == 2) begin
                total++; if (if16.locked !== 1'b0) $display("FAIL relock_early: got %0b want 0", if16.locked); else passed++;
            end
        end
        total++; if (if16.locked !== 1'b1) $display("FAIL relock: got %0b want 1", if16.locked); else passed++;
        total++; if (if16.word_count !== 16'd16) $display("FAIL stuck_word_count: got %0d want 16", if16.word_count); else passed++;
        total++; if (if16.err_lane_sticky !== (STICKY ? 8'h03 : 8'h00)) $display("FAIL stuck_sticky: got %0h want %0h", if16.err_lane_sticky, (STICKY ? 8'h03 : 8'h00)); else passed++;
    endtask

    task automatic test_wide_upper();
        logic [47:0] w;
        w = gen_word(gc); gc++;
        w[9:8] = 2'b01;
        send(w);
        total++; if (if16.err_lane !== 8'h08) $display("FAIL wide_lane: got %0h want 08", if16.err_lane); else passed++;
        total++; if (if16.err_pulse !== 1'b1) $display("FAIL wide_pulse_hi: got %0b want 1", if16.err_pulse); else passed++;
        send(gen_word(gc)); gc++;
        total++; if (if16.err_pulse !== 1'b0) $display("FAIL wide_pulse_lo: got %0b want 0", if16.err_pulse); else passed++;
        total++; if (if16.locked !== 1'b1) $display("FAIL wide_locked: got %0b want 1", if16.locked); else passed++;
        total++; if (if16.err_count !== 16'd3) $display("FAIL wide_err_count: got %0d want 3", if16.err_count); else passed++;
        total++; if (if16.err_lane_sticky !== (STICKY ? 8'h0B : 8'h00)) $display("FAIL wide_sticky: got %0h want %0h", if16.err_lane_sticky, (STICKY ? 8'h0B : 8'h00)); else passed++;
    endtask

    task automatic test_pause();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(gen_word(gc)); gc++;
        end
        total++; if (if16.word_count !== 16'd18) $display("FAIL pause_word_count: got %0d want 18", if16.word_count); else passed++;
        total++; if (if16.locked !== 1'b1) $display("FAIL pause_locked: got %0b want 1", if16.locked); else passed++;
        en = 1'b1;
        send(gen_word(gc)); gc++;
        total++; if (if16.word_count !== 16'd18) $display("FAIL resume_unchecked_wc: got %0d want 18", if16.word_count); else passed++;
        total++; if (if16.err_pulse !== 1'b0) $display("FAIL resume_unchecked_pulse: got %0b want 0", if16.err_pulse); else passed++;
        send(gen_word(gc)); gc++;
        total++; if (if16.word_count !== 16'd19) $display("FAIL resume_word_count: got %0d want 19", if16.word_count); else passed++;
        total++; if (if16.err_count !== 16'd3) $display("FAIL resume_err_count: got %0d want 3", if16.err_count); else passed++;
    endtask

    task automatic test_saturate();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; en = 1'b1;
        // All-zero words: every checked word fails L0 only.
        for (int i = 0; i < 21; i++) send(48'h0);
        total++; if (if4.err_count !== 4'd15) $display("FAIL sat_err_count4: got %0d want 15", if4.err_count); else passed++;
        total++; if (if4.word_count !== 4'd15) $display("FAIL sat_word_count4: got %0d want 15", if4.word_count); else passed++;
        total++; if (if16.err_count !== 16'd20) $display("FAIL sat_err_count16: got %0d want 20", if16.err_count); else passed++;
        total++; if (if16.locked !== 1'b0) $display("FAIL sat_locked: got %0b want 0", if16.locked); else passed++;
        clr_cnt = 1'b1;
        send(48'h0);
        clr_cnt = 1'b0;
        total++; if (if4.err_count !== 4'd1) $display("FAIL clr_err_count4: got %0d want 1", if4.err_count); else passed++;
        total++; if (if4.word_count !== 4'd1) $display("FAIL clr_word_count4: got %0d want 1", if4.word_count); else passed++;
        total++; if (if16.err_pulse !== 1'b1) $display("FAIL clr_err_pulse: got %0b want 1", if16.err_pulse); else passed++;
        total++; if (if16.err_lane_sticky !== (STICKY ? 8'h01 : 8'h00)) $display("FAIL clr_sticky: got %0h want %0h", if16.err_lane_sticky, (STICKY ? 8'h01 : 8'h00)); else passed++;
    endtask

    task automatic test_reset_mid_locked();
        logic [47:0] w;
        for (int i = 0; i < 7; i++) send(gen_word(i));
        total++; if (if16.locked !== 1'b1) $display("FAIL premid_locked: got %0b want 1", if16.locked); else passed++;
        w = gen_word(7);
        w[13:12] = 2'b10;
        send(w);
        total++; if (if16.err_lane !== 8'h10) $display("FAIL premid_lane: got %0h want 10", if16.err_lane); else passed++;
        rst_n = 1'b0;
        send(gen_word(8));
        total++; if (if16.locked !== 1'b0) $display("FAIL mid_rst_locked: got %0b want 0", if16.locked); else passed++;
        total++; if (if16.err_lane !== 8'h00) $display("FAIL mid_rst_lane: got %0h want 00", if16.err_lane); else passed++;
        total++; if (if16.err_count !== 16'd0) $display("FAIL mid_rst_err_count: got %0d want 0", if16.err_count); else passed++;
        total++; if (if16.word_count !== 16'd0) $display("FAIL mid_rst_word_count: got %0d want 0", if16.word_count); else passed++;
        total++; if (if16.err_lane_sticky !== 8'h00) $display("FAIL mid_rst_sticky: got %0h want 00", if16.err_lane_sticky); else passed++;
        rst_n = 1'b1;
        send(gen_word(3));
        total++; if (if16.word_count !== 16'd0) $display("FAIL post_rst_unchecked: got %0d want 0", if16.word_count); else passed++;
        send(gen_word(4));
        total++; if (if16.word_count !== 16'd1) $display("FAIL post_rst_checked: got %0d want 1", if16.word_count); else passed++;
        total++; if (if16.err_pulse !== 1'b0) $display("FAIL post_rst_clean: got %0b want 0", if16.err_pulse); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_lane0_stuck();
        test_wide_upper();
        test_pause();
        test_saturate();
        test_reset_mid_locked();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
